// File: rtl/ctrl_pipe_regs.sv
// Control-bundle pipeline registers (ID/EX, EX/MEM, MEM/WB) with load-use bubble insertion.
// Optional macro FWD_UNIT_EN adds EX-stage source tracking and forwarding-select outputs.
module ctrl_pipe_regs #(
    parameter int unsigned WB_W  = 2,
    parameter int unsigned M_W   = 3,
    parameter int unsigned EX_W  = 8,
    parameter int unsigned REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WB_W-1:0]  id_wb,
    input  logic [M_W-1:0]   id_m,
    input  logic [EX_W-1:0]  id_ex,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             stall,
    input  logic             flush,
    output logic [EX_W-1:0]  ex_ex,
    output logic [M_W-1:0]   ex_m,
    output logic [WB_W-1:0]  ex_wb,
    output logic [M_W-1:0]   mem_m,
    output logic [WB_W-1:0]  mem_wb,
    output logic [WB_W-1:0]  wb_wb,
    output logic [REG_W-1:0] ex_dst,
    output logic [REG_W-1:0] mem_dst,
    output logic [REG_W-1:0] wb_dst,
    output logic             lu_stall
`ifdef FWD_UNIT_EN
    ,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`endif
);

    localparam int unsigned REGDST_BIT   = 7;
    localparam int unsigned MEMREAD_BIT  = 1;
    localparam int unsigned REGWRITE_BIT = 1;

    logic [EX_W-1:0]  ex_ex_q,  ex_ex_d;
    logic [M_W-1:0]   ex_m_q,   ex_m_d;
    logic [WB_W-1:0]  ex_wb_q,  ex_wb_d;
    logic [REG_W-1:0] ex_dst_q, ex_dst_d;
    logic [M_W-1:0]   mem_m_q,  mem_m_d;
    logic [WB_W-1:0]  mem_wb_q, mem_wb_d;
    logic [REG_W-1:0] mem_dst_q, mem_dst_d;
    logic [WB_W-1:0]  wb_wb_q,  wb_wb_d;
    logic [REG_W-1:0] wb_dst_q, wb_dst_d;
`ifdef FWD_UNIT_EN
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;
`endif

    // Load in EX whose destination feeds a source of the instruction in ID.
    always_comb begin
        lu_stall = ex_m_q[MEMREAD_BIT] && (ex_dst_q != '0) && id_valid &&
                   ((ex_dst_q == id_rs) || (ex_dst_q == id_rt));
    end

    // ID/EX: flush beats stall; stall beats bubble insertion.
    always_comb begin
        ex_ex_d  = ex_ex_q;
        ex_m_d   = ex_m_q;
        ex_wb_d  = ex_wb_q;
        ex_dst_d = ex_dst_q;
`ifdef FWD_UNIT_EN
        ex_rs_d  = ex_rs_q;
        ex_rt_d  = ex_rt_q;
`endif
        if (flush || (!stall && (lu_stall || !id_valid))) begin
            ex_ex_d  = '0;
            ex_m_d   = '0;
            ex_wb_d  = '0;
            ex_dst_d = '0;
`ifdef FWD_UNIT_EN
            ex_rs_d  = '0;
            ex_rt_d  = '0;
`endif
        end else if (!stall) begin
            ex_ex_d  = id_ex;
            ex_m_d   = id_m;
            ex_wb_d  = id_wb;
            ex_dst_d = id_ex[REGDST_BIT] ? id_rd : id_rt;
`ifdef FWD_UNIT_EN
            ex_rs_d  = id_rs;
            ex_rt_d  = id_rt;
`endif
        end
    end

    // EX/MEM and MEM/WB only freeze on a global stall; a flush lets the branch retire.
    always_comb begin
        mem_m_d   = mem_m_q;
        mem_wb_d  = mem_wb_q;
        mem_dst_d = mem_dst_q;
        wb_wb_d   = wb_wb_q;
        wb_dst_d  = wb_dst_q;
        if (!stall) begin
            mem_m_d   = ex_m_q;
            mem_wb_d  = ex_wb_q;
            mem_dst_d = ex_dst_q;
            wb_wb_d   = mem_wb_q;
            wb_dst_d  = mem_dst_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ex_q   <= '0;
            ex_m_q    <= '0;
            ex_wb_q   <= '0;
            ex_dst_q  <= '0;
            mem_m_q   <= '0;
            mem_wb_q  <= '0;
            mem_dst_q <= '0;
            wb_wb_q   <= '0;
            wb_dst_q  <= '0;
`ifdef FWD_UNIT_EN
            ex_rs_q   <= '0;
            ex_rt_q   <= '0;
`endif
        end else begin
            ex_ex_q   <= ex_ex_d;
            ex_m_q    <= ex_m_d;
            ex_wb_q   <= ex_wb_d;
            ex_dst_q  <= ex_dst_d;
            mem_m_q   <= mem_m_d;
            mem_wb_q  <= mem_wb_d;
            mem_dst_q <= mem_dst_d;
            wb_wb_q   <= wb_wb_d;
            wb_dst_q  <= wb_dst_d;
`ifdef FWD_UNIT_EN
            ex_rs_q   <= ex_rs_d;
            ex_rt_q   <= ex_rt_d;
`endif
        end
    end

`ifdef FWD_UNIT_EN
    // Forwarding selects: the younger EX/MEM result takes precedence over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_wb_q[REGWRITE_BIT] && (mem_dst_q != '0) && (mem_dst_q == ex_rs_q)) begin
            fwd_a = 2'b10;
        end else if (wb_wb_q[REGWRITE_BIT] && (wb_dst_q != '0) && (wb_dst_q == ex_rs_q)) begin
            fwd_a = 2'b01;
        end
        if (mem_wb_q[REGWRITE_BIT] && (mem_dst_q != '0) && (mem_dst_q == ex_rt_q)) begin
            fwd_b = 2'b10;
        end else if (wb_wb_q[REGWRITE_BIT] && (wb_dst_q != '0) && (wb_dst_q == ex_rt_q)) begin
            fwd_b = 2'b01;
        end
    end
`endif

    assign ex_ex   = ex_ex_q;
    assign ex_m    = ex_m_q;
    assign ex_wb   = ex_wb_q;
    assign ex_dst  = ex_dst_q;
    assign mem_m   = mem_m_q;
    assign mem_wb  = mem_wb_q;
    assign mem_dst = mem_dst_q;
    assign wb_wb   = wb_wb_q;
    assign wb_dst  = wb_dst_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed, table-driven bench for ctrl_pipe_regs (forwarding checks when FWD_UNIT_EN is defined).
module tb_ctrl_pipe_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] id_wb;
    logic [2:0] id_m;
    logic [7:0] id_ex;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       stall, flush;
    logic [7:0] ex_ex;
    logic [2:0] ex_m, mem_m;
    logic [1:0] ex_wb, mem_wb, wb_wb;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic       lu_stall;
`ifdef FWD_UNIT_EN
    logic [1:0] fwd_a, fwd_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_pipe_regs dut (
        .clk(clk), .rst(rst),
        .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .stall(stall), .flush(flush),
        .ex_ex(ex_ex), .ex_m(ex_m), .ex_wb(ex_wb),
        .mem_m(mem_m), .mem_wb(mem_wb), .wb_wb(wb_wb),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .lu_stall(lu_stall)
`ifdef FWD_UNIT_EN
        ,
        .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
    );

    typedef struct {
        int wb, m, ex, valid, rs, rt, rd, st, fl;
        int x_lu;
        int x_ex, x_m, x_wb, x_dst;
        int x_mm, x_mwb, x_mdst;
        int x_wwb, x_wdst;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int wb, input int m, input int ex, input int valid,
                         input int rs, input int rt, input int rd, input int st, input int fl);
        id_wb    = 2'(wb);
        id_m     = 3'(m);
        id_ex    = 8'(ex);
        id_valid = 1'(valid);
        id_rs    = 5'(rs);
        id_rt    = 5'(rt);
        id_rd    = 5'(rd);
        stall    = 1'(st);
        flush    = 1'(fl);
    endtask

    task automatic chk_regs(input string tag, input int xex, input int xm, input int xwb,
                            input int xdst, input int xmm, input int xmwb, input int xmdst,
                            input int xwwb, input int xwdst);
        chk({tag, ".ex_ex"},   int'(ex_ex),   xex);
        chk({tag, ".ex_m"},    int'(ex_m),    xm);
        chk({tag, ".ex_wb"},   int'(ex_wb),   xwb);
        chk({tag, ".ex_dst"},  int'(ex_dst),  xdst);
        chk({tag, ".mem_m"},   int'(mem_m),   xmm);
        chk({tag, ".mem_wb"},  int'(mem_wb),  xmwb);
        chk({tag, ".mem_dst"}, int'(mem_dst), xmdst);
        chk({tag, ".wb_wb"},   int'(wb_wb),   xwwb);
        chk({tag, ".wb_dst"},  int'(wb_dst),  xwdst);
    endtask

    initial begin
        // {wb,m,ex,valid,rs,rt,rd,stall,flush, lu(before edge), ID/EX, EX/MEM, MEM/WB after edge}
        vecs[0]  = '{2,0,'h82,1,1,3,7,0,0, 0, 'h82,0,2,7, 0,0,0, 0,0};
        vecs[1]  = '{0,0,0,0,0,0,0,0,0,    0, 0,0,0,0,    0,2,7, 0,0};
        vecs[2]  = '{0,0,0,0,0,0,0,0,0,    0, 0,0,0,0,    0,0,0, 2,7};
        vecs[3]  = '{3,2,'h49,1,2,5,9,0,0, 0, 'h49,2,3,5, 0,0,0, 0,0};
        vecs[4]  = '{2,0,'h82,1,5,6,8,0,0, 1, 0,0,0,0,    2,3,5, 0,0};
        vecs[5]  = '{2,0,'h82,1,5,6,8,0,0, 0, 'h82,0,2,8, 0,0,0, 3,5};
        vecs[6]  = '{3,2,'h49,1,2,0,9,0,0, 0, 'h49,2,3,0, 0,2,8, 0,0};
        vecs[7]  = '{2,0,'h82,1,0,6,8,0,0, 0, 'h82,0,2,8, 2,3,0, 2,8};
        vecs[8]  = '{3,2,'h49,1,2,5,9,1,1, 0, 0,0,0,0,    2,3,0, 2,8};
        vecs[9]  = '{3,2,'h49,1,2,5,9,0,0, 0, 'h49,2,3,5, 0,0,0, 3,0};
        vecs[10] = '{2,0,'h82,1,1,5,8,1,0, 1, 'h49,2,3,5, 0,0,0, 3,0};
        vecs[11] = '{2,0,'h82,1,1,5,8,1,0, 1, 'h49,2,3,5, 0,0,0, 3,0};
        vecs[12] = '{2,0,'h82,1,1,5,8,1,0, 1, 'h49,2,3,5, 0,0,0, 3,0};
        vecs[13] = '{2,0,'h82,1,1,5,8,0,0, 1, 0,0,0,0,    2,3,5, 0,0};
        vecs[14] = '{2,0,'h82,1,1,5,8,0,0, 0, 'h82,0,2,8, 0,0,0, 3,5};
        vecs[15] = '{3,2,'h49,1,2,4,9,0,0, 0, 'h49,2,3,4, 0,2,8, 0,0};
        vecs[16] = '{2,0,'h82,1,4,6,8,0,1, 1, 0,0,0,0,    2,3,4, 2,8};
        vecs[17] = '{2,0,'h82,1,4,6,8,0,0, 0, 'h82,0,2,8, 0,0,0, 3,4};

        rst = 1'b1;
        drive(0,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        chk_regs("reset", 0,0,0,0, 0,0,0, 0,0);
        chk("reset.lu_stall", int'(lu_stall), 0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].wb, vecs[i].m, vecs[i].ex, vecs[i].valid,
                  vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].st, vecs[i].fl);
            #1;
            chk($sformatf("v%0d.lu_stall", i), int'(lu_stall), vecs[i].x_lu);
            @(posedge clk);
            #1;
            chk_regs($sformatf("v%0d", i), vecs[i].x_ex, vecs[i].x_m, vecs[i].x_wb, vecs[i].x_dst,
                     vecs[i].x_mm, vecs[i].x_mwb, vecs[i].x_mdst, vecs[i].x_wwb, vecs[i].x_wdst);
        end

        // Fill the pipe with R-type bundles, then reset between edges.
        drive(2,0,'h82,1,1,3,7,0,0);
        repeat (3) @(posedge clk);
        #1;
        chk_regs("full", 'h82,0,2,7, 0,2,7, 2,7);
        #2;
        rst = 1'b1;
        #1;
        chk_regs("async_rst", 0,0,0,0, 0,0,0, 0,0);
        chk("async_rst.lu_stall", int'(lu_stall), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0,0,0,0,0,0,0,0,0);
        @(posedge clk);
        #1;
        chk_regs("post_rst", 0,0,0,0, 0,0,0, 0,0);

`ifdef FWD_UNIT_EN
        // A(dst4,RegWrite) -> B(dst4,RegWrite) -> C(rs=4,rt=0): EX/MEM wins.
        drive(2,0,'h82,1,1,2,4,0,0);
        @(posedge clk); #1;
        drive(2,0,'h82,1,1,2,4,0,0);
        @(posedge clk); #1;
        drive(2,0,'h82,1,4,0,6,0,0);
        @(posedge clk); #1;
        chk("fwd_both.fwd_a", int'(fwd_a), 2);
        chk("fwd_both.fwd_b", int'(fwd_b), 0);
        // A(dst4,RegWrite) -> B(dst4,no write) -> C(rs=4): MEM/WB forwards.
        drive(2,0,'h82,1,1,2,4,0,0);
        @(posedge clk); #1;
        drive(0,0,'h82,1,1,2,4,0,0);
        @(posedge clk); #1;
        drive(2,0,'h82,1,4,0,6,0,0);
        @(posedge clk); #1;
        chk("fwd_wb.fwd_a", int'(fwd_a), 1);
        chk("fwd_wb.fwd_b", int'(fwd_b), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
